shift_seq32: RTL and testbench



---
 rtl/shift_seq32_pkg.sv | 21 ++
 rtl/shift_seq32_if.sv | 21 ++
 rtl/shift_seq32_shifter.sv | 20 ++
 rtl/shift_seq32.sv | 108 ++++++++++
 tb/tb_shift_seq32.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/shift_seq32_pkg.sv
// Shared definitions for the sequential shifter: op codes, FSM states and the
// one-hot shift-code helper used to drive the 8-bit diagonal shifters.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_BITS  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Codes of 8 and above select no tap, which yields an all-zero output.
    function automatic logic [7:0] onehot8(input logic [3:0] k);
        onehot8 = (k >= 4'd8) ? 8'h00 : (8'h01 << k[2:0]);
    endfunction

endpackage

// File: rtl/shift_seq32_if.sv
// Request/response bundle between the operand mux, the shifter and writeback.
interface shift_seq32_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    modport master (
        output in_valid, op, a, shamt, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, a, shamt, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/shift_seq32_shifter.sv
// 8-bit diagonal shifter: one-hot code s selects the shift distance, zero fill.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module ShifterLR_8 (
    input  logic [7:0] din,
    input  logic [7:0] s,
    output logic [7:0] dleft,
    output logic [7:0] dright
);
    always_comb begin
        dleft  = 8'h00;
        dright = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) begin
                dleft  = dleft  | (din << i);
                dright = dright | (din >> i);
            end
        end
    end
endmodule

// File: rtl/shift_seq32.sv
// Multi-cycle RV32 SLL/SRL/SRA: byte alignment, then one byte of bit shift per cycle.
// Latency: 5 cycles from accept to out_valid; one operation in flight.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module shift_seq32
    import shift_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    shift_seq32_if.slave  bus
);
    state_e      state;
    logic [1:0]  idx;
    logic [31:0] a_q;
    logic [4:0]  shamt_q;
    logic [1:0]  op_q;
    logic [31:0] w;
    logic [31:0] res;

    logic        right_op;
    logic [7:0]  fill;
    logic [4:0]  byte_sh;
    logic [31:0] align_w;
    logic [7:0]  w_cur;
    logic [7:0]  w_lo;
    logic [7:0]  w_hi;
    logic [7:0]  main_code;
    logic [7:0]  spill_code;
    logic [7:0]  main_l, main_r, spill_l, spill_r;
    logic [7:0]  byte_new;

    assign right_op = (op_q != OP_SLL);
    assign fill     = (op_q == OP_SRA) ? {8{a_q[31]}} : 8'h00;
    assign byte_sh  = {shamt_q[4:3], 3'b000};

    // Vacated high bytes of a right shift take the fill byte (sign for SRA).
    assign align_w = right_op
        ? ((a_q >> byte_sh) | ({4{fill}} & ~(32'hFFFF_FFFF >> byte_sh)))
        : (a_q << byte_sh);

    assign w_cur = w[{idx, 3'b000} +: 8];
    assign w_lo  = (idx == 2'd0) ? 8'h00 : w[{idx - 2'd1, 3'b000} +: 8];
    assign w_hi  = (idx == 2'd3) ? fill  : w[{idx + 2'd1, 3'b000} +: 8];

    assign main_code  = onehot8({1'b0, shamt_q[2:0]});
    assign spill_code = onehot8(4'd8 - {1'b0, shamt_q[2:0]});

    ShifterLR_8 u_main (
        .din    (w_cur),
        .s      (main_code),
        .dleft  (main_l),
        .dright (main_r)
    );

    ShifterLR_8 u_spill (
        .din    (right_op ? w_hi : w_lo),
        .s      (spill_code),
        .dleft  (spill_l),
        .dright (spill_r)
    );

    assign byte_new = right_op ? (main_r | spill_l) : (main_l | spill_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= 2'd0;
            a_q     <= 32'h0;
            shamt_q <= 5'd0;
            op_q    <= OP_SLL;
            w       <= 32'h0;
            res     <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        shamt_q <= bus.shamt;
                        op_q    <= bus.op;
                        state   <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    w     <= align_w;
                    idx   <= 2'd0;
                    state <= ST_BITS;
                end
                ST_BITS: begin
                    res[{idx, 3'b000} +: 8] <= byte_new;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = res;

endmodule

// File: tb/tb_shift_seq32.sv
// Directed bench for shift_seq32: spec vectors, backpressure, reset abort.
module tb_shift_seq32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] sb[$];

    shift_seq32_if bus();

    shift_seq32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for its result, optionally stall the consumer.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [4:0] sh, input logic [31:0] exp, input int hold);
        int n;
        logic [31:0] held;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.a        = av;
        bus.shamt    = sh;
        @(posedge clk); #1;
        sb.push_back(exp);
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.shamt    = 5'($urandom_range(0, 31));
        bus.op       = 2'($urandom_range(0, 3));
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " latency"}, n, 32'd5);
        held = bus.result;
        for (int c = 0; c < hold; c++) begin
            bus.in_valid = 1'b1;
            bus.a        = 32'h5555_AAAA;
            @(posedge clk); #1;
            check({tag, " hold result"}, bus.result, held);
            check({tag, " hold in_ready"}, {31'b0, bus.in_ready}, 32'd0);
            check({tag, " hold out_valid"}, {31'b0, bus.out_valid}, 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            check({tag, " result"}, bus.result, sb.pop_front());
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, " in_ready after"}, {31'b0, bus.in_ready}, 32'd1);
        check({tag, " out_valid after"}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 2'b00;
        bus.a         = 32'h0;
        bus.shamt     = 5'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset result", bus.result, 32'h0);

        run_op("sll4",     2'b00, 32'h1234_5678, 5'd4,  32'h2345_6780, 0);
        run_op("srl31",    2'b01, 32'h8000_0001, 5'd31, 32'h0000_0001, 0);
        run_op("srl9",     2'b01, 32'hFFFF_FFFF, 5'd9,  32'h007F_FFFF, 0);
        run_op("sra12",    2'b11, 32'h8765_4321, 5'd12, 32'hFFF8_7654, 0);
        run_op("sra31neg", 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 0);
        run_op("sra31pos", 2'b11, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 0);
        run_op("sll0",     2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0);
        run_op("srl0",     2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0);
        run_op("sra0",     2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0);
        run_op("rsv0",     2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0);
        run_op("sll8",     2'b00, 32'hAABB_CCDD, 5'd8,  32'hBBCC_DD00, 0);
        run_op("rsv4",     2'b10, 32'hF000_0000, 5'd4,  32'h0F00_0000, 0);
        run_op("sra13bp",  2'b11, 32'hC001_0F0F, 5'd13, 32'hFFFE_0008, 3);
        run_op("sll21",    2'b00, 32'h0000_0ACE, 5'd21, 32'h59C0_0000, 0);

        // Abort in BITS with idx=2: accept edge, ALIGN, idx0, idx1 -> now idx=2.
        bus.in_valid = 1'b1;
        bus.op       = 2'b01;
        bus.a        = 32'hFFFF_0000;
        bus.shamt    = 5'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("abort out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("abort result", bus.result, 32'h0);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("abort stale out_valid", seen, 32'd0);
        run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 0);

        // Reset concurrent with a request: request must be dropped.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 32'h1111_1111;
        bus.shamt    = 5'd1;
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst+req in_ready", {31'b0, bus.in_ready}, 32'd1);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("rst+req no output", seen, 32'd0);
        check("scoreboard drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
